// File: rtl/xgs_pattern_pkg.sv
// Shared types and constants for the XGS pattern stream generator.
// Used by xgs_pattern_stream_gen and xgs_crc16.
package xgs_pattern_pkg;

    typedef enum logic [1:0] {
        RAMP    = 2'd0,
        FIXED   = 2'd1,
        CHECKER = 2'd2
    } pattern_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LINE = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } gen_state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_SEED = 16'hFFFF;

    // Mode code 3 is reserved and behaves like the fixed pattern.
    function automatic pattern_mode_t decode_mode(input logic [1:0] code);
        case (code)
            2'd0:    return RAMP;
            2'd2:    return CHECKER;
            default: return FIXED;
        endcase
    endfunction

endpackage

// File: rtl/xgs_crc16.sv
// CRC-16-CCITT accumulator: folds one whole beat per cycle, least significant byte first,
// bits within each byte MSB-first (non-reflected).
module xgs_crc16
    import xgs_pattern_pkg::*;
#(
    parameter int DATA_W = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [15:0]       crc
);

    localparam int NBYTES = (DATA_W + 7) / 8;
    localparam int EXT_W  = NBYTES * 8;

    logic [EXT_W-1:0] data_ext;
    logic [15:0]      crc_next;

    assign data_ext = EXT_W'(data);

    function automatic logic [15:0] crc_fold(input logic [15:0] c_in, input logic [EXT_W-1:0] d);
        logic [15:0] c;
        c = c_in;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            c = c ^ {d[b*8 +: 8], 8'h00};
            for (int unsigned i = 0; i < 8; i++)
                c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
        end
        return c;
    endfunction

    assign crc_next = crc_fold(crc, data_ext);

    always_ff @(posedge clk) begin
        if (rst || seed)
            crc <= CRC16_SEED;
        else if (en)
            crc <= crc_next;
    end

endmodule

// File: rtl/xgs_pattern_stream_gen.sv
// Frame/line AXI4-Stream pixel pattern generator (ramp, fixed, checker).
// Optional frame CRC output enabled by defining XGS_PATTERN_CRC_EN.
module xgs_pattern_stream_gen
    import xgs_pattern_pkg::*;
#(
    parameter int PIX_W        = 10,
    parameter int PIX_PER_BEAT = 4,
    parameter int DIM_W        = 12
) (
    input  logic                          sclk,
    input  logic                          srst,
    input  logic                          start,
    input  logic [DIM_W-1:0]              cfg_beats,
    input  logic [DIM_W-1:0]              cfg_lines,
    input  logic [1:0]                    cfg_mode,
    input  logic [PIX_W-1:0]              cfg_fixed,
    input  logic [7:0]                    cfg_gap,
    output logic                          busy,
    output logic [15:0]                   frame_count,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [PIX_W*PIX_PER_BEAT-1:0] m_axis_tdata,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast
`ifdef XGS_PATTERN_CRC_EN
    ,
    output logic [15:0]                   frame_crc,
    output logic                          frame_crc_valid
`endif
);

    localparam int XW = DIM_W + $clog2(PIX_PER_BEAT);

    gen_state_t    state_q, state_d;
    pattern_mode_t mode_r;
    logic [DIM_W-1:0] beats_r, lines_r, beat_cnt, line_cnt;
    logic [PIX_W-1:0] fixed_r;
    logic [7:0]       gap_r, gap_cnt;
    logic             start_acc, beat_acc, last_beat, last_line, gap_end;

    assign start_acc = (state_q == IDLE) && start && (cfg_beats != '0) && (cfg_lines != '0);
    assign beat_acc  = m_axis_tvalid && m_axis_tready;
    assign last_beat = (beat_cnt == beats_r - DIM_W'(1));
    assign last_line = (line_cnt == lines_r - DIM_W'(1));
    assign gap_end   = (gap_cnt == gap_r - 8'd1);

    always_ff @(posedge sclk) begin
        if (srst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        busy          = (state_q != IDLE);
        m_axis_tvalid = (state_q == LINE);
        m_axis_tuser  = (state_q == LINE) && (beat_cnt == '0) && (line_cnt == '0);
        m_axis_tlast  = (state_q == LINE) && last_beat;
        case (state_q)
            IDLE: if (start_acc) state_d = LINE;
            LINE: begin
                if (beat_acc && last_beat) begin
                    if (last_line)
                        state_d = DONE;
                    else if (gap_r != '0)
                        state_d = GAP;
                    else
                        state_d = LINE;
                end
            end
            GAP:  if (gap_end) state_d = LINE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Configuration is latched only on an accepted start; counters advance on handshakes.
    always_ff @(posedge sclk) begin
        if (srst) begin
            beats_r     <= '0;
            lines_r     <= '0;
            mode_r      <= RAMP;
            fixed_r     <= '0;
            gap_r       <= '0;
            beat_cnt    <= '0;
            line_cnt    <= '0;
            gap_cnt     <= '0;
            frame_count <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_acc) begin
                        beats_r  <= cfg_beats;
                        lines_r  <= cfg_lines;
                        mode_r   <= decode_mode(cfg_mode);
                        fixed_r  <= cfg_fixed;
                        gap_r    <= cfg_gap;
                        beat_cnt <= '0;
                        line_cnt <= '0;
                    end
                end
                LINE: begin
                    if (beat_acc) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            line_cnt <= line_cnt + DIM_W'(1);
                            gap_cnt  <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + DIM_W'(1);
                        end
                    end
                end
                GAP:  gap_cnt <= gap_cnt + 8'd1;
                DONE: frame_count <= frame_count + 16'd1;
                default: ;
            endcase
        end
    end

    function automatic logic [PIX_W-1:0] pixel_at(
        input pattern_mode_t    m,
        input logic [XW-1:0]    x,
        input logic [DIM_W-1:0] y,
        input logic [15:0]      f,
        input logic [PIX_W-1:0] fixed_val
    );
        case (m)
            RAMP:    return PIX_W'(x) + PIX_W'(y) + PIX_W'(f);
            CHECKER: return (x[3] ^ y[3]) ? '1 : '0;
            default: return fixed_val;
        endcase
    endfunction

    // Pixels are a pure function of the held counters, so data stays stable during stalls.
    always_comb begin
        m_axis_tdata = '0;
        if (state_q == LINE) begin
            for (int unsigned k = 0; k < PIX_PER_BEAT; k++)
                m_axis_tdata[k*PIX_W +: PIX_W] = pixel_at(mode_r,
                    XW'(beat_cnt) * XW'(PIX_PER_BEAT) + XW'(k), line_cnt, frame_count, fixed_r);
        end
    end

`ifdef XGS_PATTERN_CRC_EN
    logic [15:0] crc_run;

    xgs_crc16 #(
        .DATA_W(PIX_W * PIX_PER_BEAT)
    ) u_crc (
        .clk (sclk),
        .rst (srst),
        .seed(start_acc),
        .en  (beat_acc),
        .data(m_axis_tdata),
        .crc (crc_run)
    );

    always_ff @(posedge sclk) begin
        if (srst)
            frame_crc <= CRC16_SEED;
        else if (state_q == DONE)
            frame_crc <= crc_run;
    end

    assign frame_crc_valid = (state_q == DONE);
`endif

endmodule
